// File: rtl/sprite_line_scheduler_if.sv
// Line-start request, descriptor read port and slot table write port of the sprite line scheduler.
// No backpressure: the descriptor bank answers one cycle after desc_idx and the slot table always accepts.
interface sprite_line_scheduler_if;
  logic        line_start;
  logic [9:0]  next_line;
  logic [4:0]  desc_idx;
  logic [31:0] desc_data;
  logic        slot_we;
  logic [2:0]  slot_idx;
  logic [4:0]  slot_id;
  logic [9:0]  slot_x;
  logic [4:0]  slot_row;
  logic [3:0]  slot_count;
  logic        overflow;
  logic        busy;
  logic        done;

  modport master (
    input  line_start, next_line, desc_data,
    output desc_idx, slot_we, slot_idx, slot_id, slot_x, slot_row,
           slot_count, overflow, busy, done
  );

  modport slave (
    output line_start, next_line, desc_data,
    input  desc_idx, slot_we, slot_idx, slot_id, slot_x, slot_row,
           slot_count, overflow, busy, done
  );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Scans all sprite descriptors on line_start and writes intersecting sprites, lowest index first, to the slot table.
// line_start to done is NUM_SPRITES+3 cycles; line_start while busy is ignored, no backpressure on slot writes.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 20,
  parameter int MAX_SLOTS   = 8,
  parameter int SPRITE_H    = 32
) (
  input logic                     clk,
  input logic                     reset,
  sprite_line_scheduler_if.master bus
);
  localparam logic [4:0]  LAST_IDX   = 5'(NUM_SPRITES - 1);
  localparam logic [3:0]  SLOT_LIMIT = 4'(MAX_SLOTS);
  localparam logic [10:0] HEIGHT     = 11'(SPRITE_H);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

  state_t      state;
  logic [9:0]  line_q;
  logic        rd_vld;

  logic        d_en;
  logic [4:0]  d_id;
  logic [9:0]  d_x;
  logic [9:0]  d_y;
  logic [10:0] line_w;
  logic [10:0] y_lo;
  logic [10:0] y_hi;
  logic        hit;
  logic        unused_desc_bits;

  assign d_en = bus.desc_data[31];
  assign d_id = bus.desc_data[30:26];
  assign d_x  = bus.desc_data[25:16];
  assign d_y  = bus.desc_data[15:6];
  assign unused_desc_bits = ^bus.desc_data[5:0];

  // 11-bit compare so a sprite near the bottom (y+H > 1023) does not wrap onto the top lines.
  assign line_w = {1'b0, line_q};
  assign y_lo   = {1'b0, d_y};
  assign y_hi   = y_lo + HEIGHT;
  assign hit    = d_en && (line_w >= y_lo) && (line_w < y_hi);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      line_q         <= '0;
      rd_vld         <= 1'b0;
      bus.desc_idx   <= '0;
      bus.slot_we    <= 1'b0;
      bus.slot_idx   <= '0;
      bus.slot_id    <= '0;
      bus.slot_x     <= '0;
      bus.slot_row   <= '0;
      bus.slot_count <= '0;
      bus.overflow   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.slot_we <= 1'b0;
      bus.done    <= 1'b0;
      // desc_data is valid exactly one cycle after each index presented in SCAN.
      rd_vld      <= (state == SCAN);

      if (rd_vld && hit) begin
        if (bus.slot_count < SLOT_LIMIT) begin
          bus.slot_we    <= 1'b1;
          bus.slot_idx   <= bus.slot_count[2:0];
          bus.slot_id    <= d_id;
          bus.slot_x     <= d_x;
          bus.slot_row   <= 5'(line_q - d_y);
          bus.slot_count <= bus.slot_count + 4'd1;
        end else begin
          bus.overflow   <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (bus.line_start) begin
            line_q         <= bus.next_line;
            bus.desc_idx   <= '0;
            bus.slot_count <= '0;
            bus.overflow   <= 1'b0;
            bus.busy       <= 1'b1;
            state          <= SCAN;
          end
        end
        SCAN: begin
          if (bus.desc_idx == LAST_IDX) begin
            state <= DRAIN;
          end else begin
            bus.desc_idx <= bus.desc_idx + 5'd1;
          end
        end
        DRAIN: begin
          state <= FIN;
        end
        FIN: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: vector table, hand-written corner sequences and randomized scans vs. a reference model.
module tb_sprite_line_scheduler;
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sprite_line_scheduler_if sif();

  sprite_line_scheduler #(.NUM_SPRITES(20), .MAX_SLOTS(8), .SPRITE_H(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  typedef struct {
    int idx;
    int id;
    int x;
    int row;
  } slot_t;

  typedef struct {
    int setup;
    int line;
    int cnt;
    int ovf;
    int id0;
    int x0;
    int row0;
  } vec_t;

  logic [31:0] bank [32];
  slot_t got_q[$];
  slot_t exp_q[$];
  int    exp_cnt;
  int    exp_ovf;
  int    done_at;
  int    n_done;
  int    obs_cnt;
  int    obs_ovf;
  int    n_vec  = 0;
  int    n_miss = 0;
  vec_t  vecs [9];

  // Registered-read descriptor bank model.
  always @(posedge clk) sif.desc_data <= bank[sif.desc_idx];

  task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int en, input int id, input int x, input int y, input int junk);
    return {en[0], id[4:0], x[9:0], y[9:0], junk[5:0]};
  endfunction

  // Reference: every enabled sprite whose 32 rows cover the line, in index order, first 8 kept.
  task automatic build_model(input int line);
    int hits;
    slot_t s;
    hits = 0;
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      int y;
      y = int'(bank[i][15:6]);
      if (bank[i][31] && line >= y && line < y + 32) begin
        hits++;
        if (exp_q.size() < 8) begin
          s.idx = exp_q.size();
          s.id  = int'(bank[i][30:26]);
          s.x   = int'(bank[i][25:16]);
          s.row = line - y;
          exp_q.push_back(s);
        end
      end
    end
    exp_cnt = exp_q.size();
    exp_ovf = (hits > 8) ? 1 : 0;
  endtask

  task automatic load_setup(input int sel);
    for (int i = 0; i < 32; i++) bank[i] = 32'd0;
    case (sel)
      1: bank[3] = mk(1, 5, 200, 90, 6'h2a);
      2: for (int i = 0; i < 10; i++) bank[i] = mk(1, i, i * 10, 0, 0);
      3: begin
        bank[0] = mk(1, 31, 1023, 1000, 6'h3f);
        bank[1] = mk(0, 7, 7, 0, 0);
      end
      default: ;
    endcase
  endtask

  // Caller is at a negedge. c counts negedges after the edge that samples line_start.
  task automatic run_scan(input int line, input bit start_now, input int n_cyc,
                          input int poke_at, input int poke_line);
    slot_t s;
    got_q.delete();
    done_at = -1;
    n_done  = 0;
    obs_cnt = -1;
    obs_ovf = -1;
    build_model(line);
    if (start_now) begin
      sif.line_start = 1'b1;
      sif.next_line  = 10'(line);
    end
    for (int c = 1; c <= n_cyc; c++) begin
      @(negedge clk);
      sif.line_start = (c == poke_at);
      if (c == poke_at) sif.next_line = 10'(poke_line);
      if (c == 1) check("busy_at_start", sif.busy, 1);
      if (sif.slot_we) begin
        s.idx = int'(sif.slot_idx);
        s.id  = int'(sif.slot_id);
        s.x   = int'(sif.slot_x);
        s.row = int'(sif.slot_row);
        got_q.push_back(s);
      end
      if (sif.done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = c;
          obs_cnt = int'(sif.slot_count);
          obs_ovf = int'(sif.overflow);
          check("busy_at_done", sif.busy, 0);
        end
      end
    end
    check("done_cycle", done_at, 23);
    check("done_pulses", n_done, 1);
    check("slot_count", obs_cnt, exp_cnt);
    check("overflow", obs_ovf, exp_ovf);
    check("write_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("slot_idx", got_q[i].idx, exp_q[i].idx);
      check("slot_id",  got_q[i].id,  exp_q[i].id);
      check("slot_x",   got_q[i].x,   exp_q[i].x);
      check("slot_row", got_q[i].row, exp_q[i].row);
    end
  endtask

  initial begin
    int writes;
    int line;
    int y;
    int poke;

    vecs[0] = '{0, 100, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 100, 1, 0, 5, 200, 10};
    vecs[2] = '{1, 89, 0, 0, 0, 0, 0};
    vecs[3] = '{1, 122, 0, 0, 0, 0, 0};
    vecs[4] = '{1, 90, 1, 0, 5, 200, 0};
    vecs[5] = '{1, 121, 1, 0, 5, 200, 31};
    vecs[6] = '{2, 5, 8, 1, 0, 0, 5};
    vecs[7] = '{3, 1020, 1, 0, 31, 1023, 20};
    vecs[8] = '{3, 5, 0, 0, 0, 0, 0};

    reset          = 1'b0;
    sif.line_start = 1'b0;
    sif.next_line  = '0;
    load_setup(0);
    repeat (3) @(negedge clk);
    check("rst_desc_idx",   sif.desc_idx, 0);
    check("rst_slot_we",    sif.slot_we, 0);
    check("rst_slot_idx",   sif.slot_idx, 0);
    check("rst_slot_id",    sif.slot_id, 0);
    check("rst_slot_x",     sif.slot_x, 0);
    check("rst_slot_row",   sif.slot_row, 0);
    check("rst_slot_count", sif.slot_count, 0);
    check("rst_overflow",   sif.overflow, 0);
    check("rst_busy",       sif.busy, 0);
    check("rst_done",       sif.done, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      load_setup(vecs[i].setup);
      run_scan(vecs[i].line, 1'b1, 26, 0, 0);
      check("vec_count", obs_cnt, vecs[i].cnt);
      check("vec_overflow", obs_ovf, vecs[i].ovf);
      if (vecs[i].cnt > 0 && got_q.size() > 0) begin
        check("vec_id0",  got_q[0].id,  vecs[i].id0);
        check("vec_x0",   got_q[0].x,   vecs[i].x0);
        check("vec_row0", got_q[0].row, vecs[i].row0);
      end
    end

    // line_start mid-scan is ignored; results belong to line 100.
    load_setup(1);
    run_scan(100, 1'b1, 26, 5, 90);

    // line_start in the done cycle starts the next scan immediately.
    run_scan(100, 1'b1, 23, 23, 90);
    run_scan(90, 1'b0, 26, 0, 0);

    // Reset mid-scan with hits still pending.
    load_setup(2);
    sif.line_start = 1'b1;
    sif.next_line  = 10'd5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      sif.line_start = 1'b0;
    end
    check("pre_reset_count", sif.slot_count, 8);
    reset = 1'b0;
    #1;
    check("mid_rst_slot_we",    sif.slot_we, 0);
    check("mid_rst_slot_count", sif.slot_count, 0);
    check("mid_rst_busy",       sif.busy, 0);
    check("mid_rst_desc_idx",   sif.desc_idx, 0);
    check("mid_rst_slot_idx",   sif.slot_idx, 0);
    check("mid_rst_overflow",   sif.overflow, 0);
    writes = 0;
    repeat (3) begin
      @(negedge clk);
      if (sif.slot_we) writes++;
    end
    reset = 1'b1;
    repeat (26) begin
      @(negedge clk);
      if (sif.slot_we || sif.done || sif.busy) writes++;
    end
    check("activity_after_reset", writes, 0);
    run_scan(5, 1'b1, 26, 0, 0);

    // Randomized scans; y clustered around the line so hits and overflow are common.
    for (int t = 0; t < 40; t++) begin
      line = $urandom_range(0, 1023);
      for (int i = 0; i < 20; i++) begin
        if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 1023);
        else y = (line - $urandom_range(0, 40)) & 1023;
        bank[i] = mk(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 31),
                     $urandom_range(0, 1023), y, $urandom_range(0, 63));
      end
      poke = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 20) : 0;
      run_scan(line, 1'b1, 26, poke, $urandom_range(0, 1023));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite scheduler between the 20-entry sprite descriptor register bank and the sprite pixel pipeline.
- On each line-start pulse it scans every descriptor and finds the sprites that intersect the next scanline.
- It writes up to MAX_SLOTS hits, in priority order (lowest descriptor index first), into the line slot table read by the pixel pipeline.
- It flags overflow when more sprites hit the line than there are slots.

Parameters:
- NUM_SPRITES, 20: number of descriptor registers scanned (index 0..NUM_SPRITES-1).
- MAX_SLOTS, 8: slot table depth; hits beyond this are dropped.
- SPRITE_H, 32: sprite height in lines; the 32x32 ROM image uses 10-bit addresses.

Ports:
- clk, in, 1: system clock; the only clock.
- reset, in, 1: reset, asynchronous, active-low.
- line_start, in, 1: one-cycle pulse requesting a scan.
- next_line, in, 10: scanline to schedule; sampled when line_start=1.
- desc_idx, out, 5: descriptor read index.
- desc_data, in, 32: descriptor word. Valid the cycle after desc_idx is presented (registered read).
- slot_we, out, 1: slot table write strobe.
- slot_idx, out, 3: slot number being written.
- slot_id, out, 5: ROM/image select, from desc[30:26].
- slot_x, out, 10: sprite left x, from desc[25:16].
- slot_row, out, 5: next_line - y; the row within the sprite image.
- slot_count, out, 4: number of slots written this scan.
- overflow, out, 1: more than MAX_SLOTS hits this scan.
- busy, out, 1: scan in progress.
- done, out, 1: one-cycle pulse when a scan completes.

Behaviour:
- Descriptor format:
  - [31] enable
  - [30:26] id
  - [25:16] x
  - [15:6] y
  - [5:0] ignored
- Reset (reset=0, async): state IDLE. Outputs and internal registers:
  - desc_idx=0, slot_we=0, slot_idx=0, slot_id=0, slot_x=0, slot_row=0
  - slot_count=0, overflow=0, busy=0, done=0
  - internal line register=0
- States: IDLE -> SCAN -> DRAIN -> FIN -> IDLE.
- IDLE:
  - On line_start=1: latch next_line, set desc_idx=0, clear slot_count and overflow, set busy=1, go to SCAN.
  - line_start=0: stay in IDLE.
- SCAN:
  - desc_idx increments by 1 each cycle.
  - When desc_idx=NUM_SPRITES-1 is presented, the next state is DRAIN.
  - Starting one cycle after entry, each cycle evaluates the desc_data returned for the previous index.
- DRAIN: evaluates the last descriptor (index NUM_SPRITES-1), then goes to FIN.
- FIN:
  - done=1 for one cycle, busy=0, then IDLE.
  - slot_count and overflow hold their values until the next line_start.
- Hit rule:
  - Hit when enable=1 and y <= line < y+SPRITE_H.
  - Compare in 11-bit unsigned arithmetic, so y+32 never wraps (y=1000 gives upper bound 1032).
  - slot_row = (line - y)[4:0].
- On a hit with slot_count < MAX_SLOTS:
  - Registered outputs, one cycle after evaluation: slot_we=1, slot_idx=slot_count, slot_id, slot_x, slot_row.
  - slot_count increments.
- On a hit with slot_count = MAX_SLOTS: no write; set overflow=1 (sticky for the scan).
- slot_we is 0 on every non-hit cycle.
- Timing: line_start to done is exactly NUM_SPRITES+3 cycles; 23 cycles at default.
- line_start while busy=1 is ignored. No restart, no effect on latched line.
- line_start in the same cycle as done: accepted; the new scan begins next cycle.
- Reset asserted mid-scan: immediate return to the reset values; no further slot writes.
- Slots beyond slot_count are stale. Consumers use only slot_count entries.

Test Plan:
- Reset, then line_start with next_line=100 and all descriptors 0 -> no slot_we. done exactly 23 cycles after line_start; slot_count=0, overflow=0.
- Descriptor 3 = enable, id=5, x=200, y=90; line 100 -> one write: slot_idx=0, id=5, x=200, row=10; slot_count=1.
- Boundaries with y=90: line 89 and line 122 -> no hit; line 90 -> row 0; line 121 -> row 31.
- Ten enabled descriptors (indices 0..9) with y=0, line 5 -> slots 0..7 hold indices 0..7 in order; slot_count=8, overflow=1.
- line_start pulsed at cycle 5 of a scan -> ignored; single done at 23 cycles with the original line's results.
- reset driven low at cycle 10 of a scan with hits pending -> all outputs 0 asynchronously; no slot_we afterwards; a fresh line_start works normally.
